// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the 8-digit 7-segment scan controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Holds the register-select encodings, the CTRL reset value and the
// hex-to-segment table (gfedcba, active high).
package seg_scan_ctrl_pkg;

  localparam logic SEL_DATA = 1'b0;
  localparam logic SEL_CTRL = 1'b1;

  // CTRL[7:0] = digit enable mask, CTRL[15:8] = dp mask, upper half unused.
  localparam logic [31:0] CTRL_RST = 32'h0000_00FF;

  // Index n holds the segment pattern for hex digit n; element 15 is listed first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Hex nibble to 7-segment pattern decoder (gfedcba, active high).
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   nib_i  4-bit hex digit
//   seg_o  7-bit segment pattern, bit 0 = a ... bit 6 = g
module seg_scan_ctrl_hex7seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Memory-mapped 8-digit 7-segment scan controller with blanking.
// Latency: outputs registered, 1 cycle after scan/register state change.
// Backpressure: none; every write strobe is accepted immediately.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wen_i, sel_i        write strobe and register select (0 DATA, 1 CTRL)
//   wdata_i / rdata_o   write data / combinational readback of selected reg
//   led_en_o            active-low digit enables, bit i = digit i
//   led_ca_o..led_cg_o  active-low segments a..g
//   led_dp_o            active-low decimal point
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int SCAN_CYCLES  = 20000,
  parameter int BLANK_CYCLES = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wen_i,
  input  logic        sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  led_en_o,
  output logic        led_ca_o,
  output logic        led_cb_o,
  output logic        led_cc_o,
  output logic        led_cd_o,
  output logic        led_ce_o,
  output logic        led_cf_o,
  output logic        led_cg_o,
  output logic        led_dp_o
);

  localparam int CNT_W = $clog2(SCAN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [31:0]      data_q;
  logic [7:0]       en_mask_q;
  logic [7:0]       dp_mask_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;

  logic [3:0]       nibble;
  logic [6:0]       seg_hi;
  logic             blank;
  logic [7:0]       en_nxt;

  logic [7:0]       led_en_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  // Register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      en_mask_q <= CTRL_RST[7:0];
      dp_mask_q <= CTRL_RST[15:8];
    end else if (wen_i) begin
      if (sel_i == SEL_CTRL) begin
        en_mask_q <= wdata_i[7:0];
        dp_mask_q <= wdata_i[15:8];
      end else begin
        data_q <= wdata_i;
      end
    end
  end

  assign rdata_o = (sel_i == SEL_DATA) ? data_q : {16'h0, dp_mask_q, en_mask_q};

  // Scan position; free-running regardless of the enable mask so that the
  // digit rotation never drifts when digits are masked off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign nibble = data_q[{idx, 2'b00} +: 4];

  seg_scan_ctrl_hex7seg u_hex7seg (
    .nib_i (nibble),
    .seg_o (seg_hi)
  );

  // Leading blank cycles of each slot let the previous digit's driver turn
  // off before the next one lights, which avoids ghosting.
  assign blank  = (cnt < BLANK_END) || !en_mask_q[idx];
  assign en_nxt = blank ? 8'hFF : ~(8'h01 << idx);

  // Output registers: idx and DATA are sampled together, so a write that
  // lands on a slot wrap can never show a mixed digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_en_q <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      led_en_q <= en_nxt;
      seg_q    <= ~seg_hi;
      dp_q     <= ~dp_mask_q[idx];
    end
  end

  assign led_en_o = led_en_q;
  assign led_ca_o = seg_q[0];
  assign led_cb_o = seg_q[1];
  assign led_cc_o = seg_q[2];
  assign led_cd_o = seg_q[3];
  assign led_ce_o = seg_q[4];
  assign led_cf_o = seg_q[5];
  assign led_cg_o = seg_q[6];
  assign led_dp_o = dp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_CYCLES=4, BLANK_CYCLES=1.
// Each slot is 4 cycles: one blank cycle then three lit cycles; outputs lag
// the scan state by one cycle.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wen;
  logic        sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  led_en;
  logic        ca, cb, cc, cd, ce, cf, cg, dp;
  logic [6:0]  seg;

  int total = 0;
  int bad   = 0;

  // Active-high patterns for digits F,E,d,C,b,A,9,8 (DATA=89AB_CDEF, idx 0..7).
  logic [6:0] seg_tbl [8] = '{7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F};
  logic [7:0] en_all  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] en_55   [8] = '{8'hFE, 8'hFF, 8'hFB, 8'hFF, 8'hEF, 8'hFF, 8'hBF, 8'hFF};
  logic       dp_01   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  assign seg = {cg, cf, ce, cd, cc, cb, ca};

  seg_scan_ctrl #(
    .SCAN_CYCLES  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wen_i    (wen),
    .sel_i    (sel),
    .wdata_i  (wdata),
    .rdata_o  (rdata),
    .led_en_o (led_en),
    .led_ca_o (ca),
    .led_cb_o (cb),
    .led_cc_o (cc),
    .led_cd_o (cd),
    .led_ce_o (ce),
    .led_cf_o (cf),
    .led_cg_o (cg),
    .led_dp_o (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic s, input logic [31:0] d);
    wen   = 1'b1;
    sel   = s;
    wdata = d;
    tick();
    wen   = 1'b0;
  endtask

  // One full slot: blank cycle, then three lit cycles.
  task automatic check_slot(input logic [7:0] lit_en, input logic dp_exp, input logic [6:0] seg_hi);
    logic [6:0] seg_lo;
    seg_lo = ~seg_hi;
    tick();
    chk("slot_blank_en", led_en, 8'hFF);
    chk("slot_blank_seg", seg, seg_lo);
    repeat (3) begin
      tick();
      chk("slot_lit_en", led_en, lit_en);
      chk("slot_seg", seg, seg_lo);
      chk("slot_dp", dp, dp_exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wen   = 1'b0;
    sel   = 1'b0;
    wdata = 32'h0;

    // 1. Reset state and first lit slot.
    tick(3);
    chk("rst_en", led_en, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    sel = 1'b0; #1;
    chk("rst_rd_data", rdata, 32'h0);
    sel = 1'b1; #1;
    chk("rst_rd_ctrl", rdata, 32'h0000_00FF);
    sel = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("first_blank", led_en, 8'hFF);
    tick();
    chk("first_lit_en", led_en, 8'hFE);
    chk("first_lit_seg", seg, 7'h40);
    chk("first_lit_dp", dp, 1'b1);

    // 2. DATA=89AB_CDEF, walk all eight digits and the wrap back to idx0.
    wr(1'b0, 32'h89AB_CDEF);
    chk("rd_data", rdata, 32'h89AB_CDEF);
    tick();
    chk("idx0_new_en", led_en, 8'hFE);
    chk("idx0_new_seg", seg, 7'h0E);
    for (int k = 1; k <= 8; k++)
      check_slot(en_all[k % 8], 1'b1, seg_tbl[k % 8]);

    // 3. CTRL=0155: odd digits masked, dp on digit 0 only.
    wr(1'b1, 32'h0000_0155);
    chk("rd_ctrl_155", rdata, 32'h0000_0155);
    repeat (3) begin
      tick();
      chk("masked_idx1_en", led_en, 8'hFF);
    end
    for (int k = 10; k <= 17; k++)
      check_slot(en_55[k % 8], dp_01[k % 8], seg_tbl[k % 8]);

    // Upper CTRL bits are ignored on write.
    wr(1'b1, 32'hABCD_00FF);
    chk("rd_ctrl_upper", rdata, 32'h0000_00FF);

    // 4. Mid-slot DATA write at cnt=2, idx=3.
    wr(1'b0, 32'h0);
    tick(4);
    chk("pre_wr_en", led_en, 8'hF7);
    chk("pre_wr_seg", seg, 7'h40);
    wr(1'b0, 32'h0000_5000);
    chk("wr_plus1_seg", seg, 7'h40);
    tick();
    chk("wr_plus2_seg", seg, 7'h12);
    chk("wr_plus2_en", led_en, 8'hF7);
    tick();
    chk("slot_end_blank", led_en, 8'hFF);
    chk("slot_end_seg", seg, 7'h40);

    // 5. Mask all digits off, then restore and land on the expected idx.
    wr(1'b1, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mask0_en", led_en, 8'hFF);
    end
    chk("rd_ctrl_0", rdata, 32'h0);
    wr(1'b1, 32'h0000_00FF);
    tick();
    chk("restore_idx1_en", led_en, 8'hFD);

    // 6. Asynchronous reset in the middle of the idx5 slot.
    tick(14);
    chk("idx5_lit_en", led_en, 8'hDF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", led_en, 8'hFF);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_dp", dp, 1'b1);
    sel = 1'b0; #1;
    chk("arst_rd_data", rdata, 32'h0);
    tick();
    chk("arst_hold_en", led_en, 8'hFF);
    rst_n = 1'b1;
    tick();
    chk("rerun_blank", led_en, 8'hFF);
    tick();
    chk("rerun_idx0_en", led_en, 8'hFE);
    chk("rerun_idx0_seg", seg, 7'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
